ssd_share_ctrl: RTL and testbench

//  Shares the 4-digit seven-segment display between two requesters. Each requester

---
 rtl/ssd_pkg.sv | 23 ++
 rtl/ssd_char_decode.sv | 37 +++
 rtl/ssd_share_ctrl.sv | 151 +++++++++++++++
 tb/tb_ssd_share_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants and types for the shared seven-segment display controller.
package ssd_pkg;

    localparam logic [4:0] CH_BLANK = 5'h10;
    localparam logic [4:0] CH_DASH  = 5'h11;
    localparam logic [4:0] CH_L     = 5'h12;
    localparam logic [4:0] CH_H     = 5'h13;
    localparam logic [4:0] CH_P     = 5'h14;
    localparam logic [4:0] CH_U     = 5'h15;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Four blank characters, used as the snapshot contents out of reset.
    localparam logic [19:0] SNAP_BLANK = {4{CH_BLANK}};

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ssd_char_decode.sv
// Combinational 5-bit character code to active-low {g,f,e,d,c,b,a} segment pattern.
module ssd_char_decode
    import ssd_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            5'h00:    seg = 7'b1000000;
            5'h01:    seg = 7'b1111001;
            5'h02:    seg = 7'b0100100;
            5'h03:    seg = 7'b0110000;
            5'h04:    seg = 7'b0011001;
            5'h05:    seg = 7'b0010010;
            5'h06:    seg = 7'b0000010;
            5'h07:    seg = 7'b1111000;
            5'h08:    seg = 7'b0000000;
            5'h09:    seg = 7'b0010000;
            5'h0A:    seg = 7'b0001000;
            5'h0B:    seg = 7'b0000011;
            5'h0C:    seg = 7'b1000110;
            5'h0D:    seg = 7'b0100001;
            5'h0E:    seg = 7'b0000110;
            5'h0F:    seg = 7'b0001110;
            CH_DASH:  seg = 7'b0111111;
            CH_L:     seg = 7'b1000111;
            CH_H:     seg = 7'b0001001;
            CH_P:     seg = 7'b0001100;
            CH_U:     seg = 7'b1000001;
            default:  seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ssd_share_ctrl.sv
// Two-requester share controller for a 4-digit multiplexed seven-segment display:
// frame-boundary round-robin arbitration with minimum dwell, snapshot, and scan.
module ssd_share_ctrl
    import ssd_pkg::*;
#(
    parameter int               CNT_W   = 10,
    parameter logic [CNT_W-1:0] CNT_MAX = 10'd1023,
    parameter int               DWELL   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [19:0] chars0,
    input  logic [19:0] chars1,
    output logic [1:0]  gnt,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_tick
);

    localparam int                 DWELL_W   = $clog2(DWELL + 1);
    localparam logic [DWELL_W-1:0] DWELL_SAT = DWELL_W'(DWELL);

    logic [CNT_W-1:0]   cnt;
    logic [1:0]         digit;
    logic [1:0]         digit_nx;
    logic               wrap;
    logic               boundary;
    arb_state_t         state;
    arb_state_t         state_nx;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] dwell_nx;
    logic [DWELL_W-1:0] dwell_inc;
    logic               rr;
    logic               rr_nx;
    logic [19:0]        snap;
    logic [19:0]        snap_nx;
    logic [1:0]         gnt_nx;
    logic [4:0]         code_p0;
    logic [6:0]         seg_p0;

    assign wrap      = (cnt == CNT_MAX);
    assign boundary  = wrap && (digit == 2'd3);
    assign digit_nx  = wrap ? digit + 2'd1 : digit;
    assign dwell_inc = (dwell >= DWELL_SAT) ? DWELL_SAT : dwell + DWELL_W'(1);

    // Arbitration only moves at a frame boundary so a frame is never torn.
    always_comb begin
        state_nx = state;
        dwell_nx = dwell;
        rr_nx    = rr;
        if (boundary) begin
            unique case (state)
                ARB_IDLE: begin
                    dwell_nx = '0;
                    if (req == 2'b11)
                        state_nx = rr ? ARB_OWN1 : ARB_OWN0;
                    else if (req[0])
                        state_nx = ARB_OWN0;
                    else if (req[1])
                        state_nx = ARB_OWN1;
                end
                ARB_OWN0: begin
                    if (!req[0]) begin
                        dwell_nx = '0;
                        state_nx = req[1] ? ARB_OWN1 : ARB_IDLE;
                    end else if (req[1] && (dwell_inc >= DWELL_SAT)) begin
                        state_nx = ARB_OWN1;
                        dwell_nx = '0;
                        rr_nx    = 1'b0;
                    end else begin
                        dwell_nx = dwell_inc;
                    end
                end
                ARB_OWN1: begin
                    if (!req[1]) begin
                        dwell_nx = '0;
                        state_nx = req[0] ? ARB_OWN0 : ARB_IDLE;
                    end else if (req[0] && (dwell_inc >= DWELL_SAT)) begin
                        state_nx = ARB_OWN0;
                        dwell_nx = '0;
                        rr_nx    = 1'b1;
                    end else begin
                        dwell_nx = dwell_inc;
                    end
                end
                default: begin
                    state_nx = ARB_IDLE;
                    dwell_nx = '0;
                end
            endcase
        end
    end

    assign gnt_nx = {state_nx == ARB_OWN1, state_nx == ARB_OWN0};

    always_comb begin
        snap_nx = snap;
        if (boundary && (state_nx == ARB_OWN0))
            snap_nx = chars0;
        else if (boundary && (state_nx == ARB_OWN1))
            snap_nx = chars1;
    end

    always_comb begin
        code_p0 = snap_nx[4:0];
        case (digit_nx)
            2'd1:    code_p0 = snap_nx[9:5];
            2'd2:    code_p0 = snap_nx[14:10];
            2'd3:    code_p0 = snap_nx[19:15];
            default: code_p0 = snap_nx[4:0];
        endcase
    end

    ssd_char_decode u_decode (
        .code (code_p0),
        .seg  (seg_p0)
    );

    // Stage boundary: next-state digit/owner/snapshot registered into an/seg together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            digit      <= 2'd0;
            state      <= ARB_IDLE;
            dwell      <= '0;
            rr         <= 1'b0;
            snap       <= SNAP_BLANK;
            seg        <= SEG_BLANK;
            an         <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= wrap ? '0 : cnt + CNT_W'(1);
            digit      <= digit_nx;
            state      <= state_nx;
            dwell      <= dwell_nx;
            rr         <= rr_nx;
            snap       <= snap_nx;
            frame_tick <= boundary;
            if (wrap) begin
                an  <= (gnt_nx != 2'b00) ? ~(4'b0001 << digit_nx) : AN_OFF;
                seg <= (gnt_nx != 2'b00) ? seg_p0 : SEG_BLANK;
            end
        end
    end

    assign gnt = {state == ARB_OWN1, state == ARB_OWN0};
    assign dp  = 1'b1;

endmodule

// File: tb/tb_ssd_share_ctrl.sv
// Directed bench for ssd_share_ctrl with CNT_MAX=3 (16-cycle frames) and DWELL=2.
module tb_ssd_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [19:0] chars0 = 20'h0;
    logic [19:0] chars1 = 20'h0;
    logic [1:0]  gnt;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    ssd_share_ctrl #(
        .CNT_W   (10),
        .CNT_MAX (10'd3),
        .DWELL   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .chars0     (chars0),
        .chars1     (chars1),
        .gnt        (gnt),
        .seg        (seg),
        .an         (an),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(input string tag);
        int k = 0;
        @(negedge clk);
        while (frame_tick !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(frame_tick), 32'd1);
    endtask

    logic [6:0] t2_seg [4] = '{7'h79, 7'h46, 7'h0E, 7'h47};

    initial begin
        int first = 0;
        int second = 0;
        int idle_bad = 0;
        logic [3:0] exp_an;

        step(3);
        chk("rst_seg",  32'(seg),        32'h7F);
        chk("rst_an",   32'(an),         32'hF);
        chk("rst_gnt",  32'(gnt),        32'h0);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        chk("rst_dp",   32'(dp),         32'h1);
        rst_n = 1'b1;

        // Idle: blank display, tick every 16 cycles.
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                if (first == 0) first = i;
                else if (second == 0) second = i;
            end
            if (an !== 4'hF || seg !== 7'h7F || gnt !== 2'b00) idle_bad++;
        end
        chk("t1_first_tick", 32'(first), 32'd16);
        chk("t1_tick_period", 32'(second - first), 32'd16);
        chk("t1_idle_blank", 32'(idle_bad), 32'd0);

        // Single requester 0, full frame scan.
        req    = 2'b01;
        chars0 = {5'h12, 5'h0F, 5'h0C, 5'h01};
        chars1 = {5'h13, 5'h14, 5'h15, 5'h0A};
        step(15);
        chk("t2_gnt_before", 32'(gnt), 32'h0);
        chk("t2_an_before",  32'(an),  32'hF);
        step(1);
        chk("t2_tick", 32'(frame_tick), 32'd1);
        chk("t2_gnt",  32'(gnt),        32'h1);
        for (int k = 0; k < 16; k++) begin
            exp_an = ~(4'b0001 << (k / 4));
            chk("t2_scan", 32'({an, seg}), 32'({exp_an, t2_seg[k / 4]}));
            if (k == 1) chk("t2_tick_pulse", 32'(frame_tick), 32'd0);
            if (k < 15) step(1);
        end

        // Release to idle, then both request: strict alternation after 2 frames each.
        req = 2'b00;
        step(1);
        chk("t3_release_gnt", 32'(gnt), 32'h0);
        chk("t3_release_an",  32'(an),  32'hF);
        req = 2'b11;
        wait_tick("t3_tick_a");
        chk("t3_gnt_first", 32'(gnt), 32'h1);
        wait_tick("t3_tick_b");
        chk("t3_gnt_dwell0", 32'(gnt), 32'h1);
        wait_tick("t3_tick_c");
        chk("t3_gnt_switch1", 32'(gnt), 32'h2);
        chk("t3_owner1_disp", 32'({an, seg}), 32'({4'hE, 7'h08}));
        wait_tick("t3_tick_d");
        chk("t3_gnt_dwell1", 32'(gnt), 32'h2);
        wait_tick("t3_tick_e");
        chk("t3_gnt_switch0", 32'(gnt), 32'h1);

        // Owner 0 drops req mid-frame: frame completes, then idle.
        step(6);
        req = 2'b00;
        step(1);
        chk("t4_hold_gnt_mid", 32'(gnt), 32'h1);
        chk("t4_hold_disp_mid", 32'({an, seg}), 32'({4'hD, 7'h46}));
        step(8);
        chk("t4_hold_gnt_end", 32'(gnt), 32'h1);
        chk("t4_hold_disp_end", 32'({an, seg}), 32'({4'h7, 7'h47}));
        step(1);
        chk("t4_idle_gnt", 32'(gnt), 32'h0);
        chk("t4_idle_disp", 32'({an, seg}), 32'({4'hF, 7'h7F}));

        // Mid-frame chars change shows only from the next frame.
        req = 2'b01;
        wait_tick("t5_tick_a");
        chk("t5_gnt", 32'(gnt), 32'h1);
        step(2);
        chars0 = {4{5'h11}};
        step(3);
        chk("t5_old_d1", 32'({an, seg}), 32'({4'hD, 7'h46}));
        step(8);
        chk("t5_old_d3", 32'({an, seg}), 32'({4'h7, 7'h47}));
        wait_tick("t5_tick_b");
        chk("t5_new_d0", 32'({an, seg}), 32'({4'hE, 7'h3F}));
        step(9);
        chk("t5_new_d2", 32'({an, seg}), 32'({4'hB, 7'h3F}));

        // Unused code blanks its digit; async reset mid-frame.
        chars0 = {5'h11, 5'h1F, 5'h11, 5'h11};
        wait_tick("t6_tick_a");
        chk("t6_d0", 32'({an, seg}), 32'({4'hE, 7'h3F}));
        step(8);
        chk("t6_d2_blank", 32'({an, seg}), 32'({4'hB, 7'h7F}));
        step(2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_an",  32'(an),  32'hF);
        chk("t6_async_gnt", 32'(gnt), 32'h0);
        chk("t6_async_seg", 32'(seg), 32'h7F);
        step(2);
        chk("t6_rst_tick", 32'(frame_tick), 32'd0);
        rst_n = 1'b1;
        step(15);
        chk("t6_post_rst_gnt", 32'(gnt), 32'h0);
        step(1);
        chk("t6_post_rst_tick", 32'(frame_tick), 32'd1);
        chk("t6_post_rst_gnt1", 32'(gnt), 32'h1);
        chk("t6_post_rst_disp", 32'({an, seg}), 32'({4'hE, 7'h3F}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
